ahb_burst_master: RTL
=====================

Name: ahb_burst_master

Overview:
- Synthesizable, parametrised AHB-Lite master burst engine.
- Replaces the task-driven read/write/burst sequences with RTL: accepts one command at a time (address, direction, beat count, BUSY insertion) and drives pipelined address/data phases to the memory slave.
- Honours HREADY wait states and HRESP errors, and returns read data as a stream.
- Sits between test/sequencer logic and the AHB slave modport signals.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and cmd_addr.
- DATA_WIDTH, 32, width of HWDATA/HRDATA; legal values 8/16/32/64.
- MAX_BEATS, 16, maximum beats per command.
- BUSY_W, 2, width of cmd_busy (BUSY cycles to insert).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_addr  in  ADDR_WIDTH  start byte address, aligned to DATA_WIDTH/8.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_beats  in  $clog2(MAX_BEATS+1)  beat count; 0 is treated as 1.
- cmd_busy  in  BUSY_W  BUSY cycles inserted after beat 0.
- wdata  in  DATA_WIDTH  next write beat; must be valid whenever wdata_pop would fire.
- wdata_pop  out  1  wdata consumed this cycle.
- rdata  out  DATA_WIDTH  captured read beat.
- rdata_valid  out  1  rdata valid (1-cycle pulse per beat).
- done  out  1  1-cycle pulse when a command finishes.
- error  out  1  qualifies done; slave error or rejected command.
- HADDR  out  ADDR_WIDTH  address phase.
- HWRITE  out  1  direction.
- HSIZE  out  3  fixed $clog2(DATA_WIDTH/8).
- HBURST  out  3  burst type.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWDATA  out  DATA_WIDTH  write data phase.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  transfer complete.
- HRESP  in  1  error response.

Behaviour:
- Reset values:
  - HADDR=0, HTRANS=IDLE, HWRITE=0, HBURST=000, HWDATA=0.
  - rdata=0, rdata_valid=0, wdata_pop=0, done=0, error=0.
  - HSIZE=constant; state=IDLE.
- cmd_ready = (state==IDLE), combinational. Command is accepted when cmd_valid & cmd_ready.
- All AHB outputs are registered.
- FSM states: IDLE, ADDR, BUSYW, LAST, ERR.
  - IDLE -> ADDR on accept. On the next edge: HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE, HBURST.
  - HBURST mapping: beats 1 -> 000 SINGLE, 4 -> 011 INCR4, 8 -> 101 INCR8, 16 -> 111 INCR16, any other value -> 001 INCR.
  - Address phase is accepted at an edge with HREADY=1.
  - After acceptance, HADDR increments by DATA_WIDTH/8 (no wrap; truncation to ADDR_WIDTH).
  - After beat 0 is accepted, with beats>1 and cmd_busy=N>0: go to BUSYW.
    - Drive HTRANS=BUSY for exactly N HREADY-high cycles, with HADDR holding the beat-1 address.
    - Then drive SEQ.
  - Subsequent beats use SEQ.
  - After the last address phase is accepted: HTRANS=IDLE and go to LAST, waiting for its data phase.
  - LAST -> IDLE when the final data phase completes (HREADY=1). done=1, error=0 in the same cycle.
- Pipelining: the data phase of beat n overlaps the address phase of beat n+1.
  - Write: HWDATA is loaded from wdata at the edge that accepts that beat's address phase. wdata_pop=1 in that cycle.
  - Read: rdata=HRDATA and rdata_valid=1 on each data-phase edge with HREADY=1.
  - Single-beat latency: command accept -> done = 3 cycles with zero wait states.
- HREADY=0: hold HADDR, HTRANS, HWRITE, HBURST, HWDATA unchanged. No pops, no rdata_valid.
- Error handling:
  - A data phase with HRESP=1 & HREADY=0 (first error cycle) makes the next edge drive HTRANS=IDLE, cancelling the remaining beats, and go to ERR.
  - ERR -> IDLE when HREADY=1 (second error cycle) with done=1, error=1.
  - No rdata_valid for the erroring beat. No further wdata_pop.
- HRESET mid-burst:
  - Next edge forces reset values; the burst is abandoned.
  - No done pulse. Partial rdata already emitted stands.
- cmd_valid while busy: ignored (cmd_ready=0). The command is held by the source.

Optional Feature:
- Macro: AHB_BURST_MASTER_1KB_CHECK_EN.
- Defined:
  - At accept, if cmd_addr + beats*(DATA_WIDTH/8) - 1 crosses a 1 KB boundary, the command is rejected.
  - Rejection: no bus activity, HTRANS stays IDLE, done=1 and error=1 on the next cycle, then IDLE.
- Undefined: no check; the burst is issued as is.

Test Plan:
- Single write: addr 0x10, data 0xDEADBEEF, HREADY=1 -> NONSEQ @0x10, HBURST=000, HWDATA=0xDEADBEEF one cycle later, done at cycle 3, error=0.
- INCR4 read: addr 0x40, slave returns 1,2,3,4 -> HADDR 0x40/44/48/4C, HTRANS NONSEQ,SEQ,SEQ,SEQ, HBURST=011, four rdata_valid pulses with 1..4 in order.
- INCR8 write, cmd_busy=2 -> NONSEQ, then 2 BUSY cycles with HADDR=addr+4, then 7 SEQ; 8 wdata_pops; HWDATA stable across the BUSY cycles.
- Wait states: INCR4 read, HREADY low for 2 cycles on beat 2 -> all AHB outputs held, done delayed by exactly 2 cycles, data order unchanged.
- Error: beat 1 of INCR4 write gets HRESP=1 for 2 cycles -> HTRANS=IDLE after the first error cycle, done=1 and error=1, only 2 wdata_pops.
- Reset at beat 2 of INCR16 read -> HTRANS=IDLE next edge, no done, cmd_ready=1. With the macro defined, addr 0x3F8 with 4 beats (32-bit) -> rejected with done=1, error=1, no NONSEQ.

Source files
------------

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master burst engine.
// Takes one command at a time (start address, direction, beat count, BUSY
// insertion) and drives pipelined address/data phases on the AHB bus.
// Honours HREADY wait states and the two-cycle HRESP error response.
// Read data comes back as a stream on rdata/rdata_valid.
// Optional build macro AHB_BURST_MASTER_1KB_CHECK_EN rejects commands whose
// burst would cross a 1 KB address boundary.
module ahb_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int BUSY_W     = 2
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic                             cmd_write,
    input  logic [$clog2(MAX_BEATS+1)-1:0]   cmd_beats,
    input  logic [BUSY_W-1:0]                cmd_busy,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic                             wdata_pop,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rdata_valid,
    output logic                             done,
    output logic                             error,
    output logic [ADDR_WIDTH-1:0]            HADDR,
    output logic                             HWRITE,
    output logic [2:0]                       HSIZE,
    output logic [2:0]                       HBURST,
    output logic [1:0]                       HTRANS,
    output logic [DATA_WIDTH-1:0]            HWDATA,
    input  logic [DATA_WIDTH-1:0]            HRDATA,
    input  logic                             HREADY,
    input  logic                             HRESP
);

    localparam int BEAT_W = $clog2(MAX_BEATS+1);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam logic [2:0]            SIZE_CODE = 3'($clog2(BYTES));
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BUSYW,
        S_LAST,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // Beats not yet placed on the bus, BUSY bookkeeping and data-phase tracking
    logic [BEAT_W-1:0]     beats_rem;
    logic [BEAT_W-1:0]     beats_rem_nxt;
    logic [BUSY_W-1:0]     busy_n;
    logic [BUSY_W-1:0]     busy_n_nxt;
    logic [BUSY_W-1:0]     busy_cnt;
    logic [BUSY_W-1:0]     busy_cnt_nxt;
    logic                  dphase;
    logic                  dphase_nxt;

    logic [ADDR_WIDTH-1:0] haddr_nxt;
    logic [1:0]            htrans_nxt;
    logic                  hwrite_nxt;
    logic [2:0]            hburst_nxt;
    logic [DATA_WIDTH-1:0] hwdata_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  rvalid_nxt;
    logic                  done_nxt;
    logic                  error_nxt;

    logic                  accept;
    logic                  reject;
    logic                  addr_acc;
    logic                  err_first;
    logic [BEAT_W-1:0]     eff_beats;

    function automatic logic [2:0] burst_code(input logic [BEAT_W-1:0] n);
        case (int'(n))
            1:       return 3'b000;
            4:       return 3'b011;
            8:       return 3'b101;
            16:      return 3'b111;
            default: return 3'b001;
        endcase
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign eff_beats = (cmd_beats == '0) ? BEAT_W'(1) : cmd_beats;
    assign addr_acc  = (state == S_ADDR) & HREADY;
    assign wdata_pop = addr_acc & HWRITE;
    assign err_first = dphase & HRESP & ~HREADY & (state != S_ERR) & (state != S_IDLE);
    assign HSIZE     = SIZE_CODE;

`ifdef AHB_BURST_MASTER_1KB_CHECK_EN
    logic [ADDR_WIDTH:0] last_byte;
    assign last_byte = {1'b0, cmd_addr}
                     + ((ADDR_WIDTH+1)'(eff_beats) * (ADDR_WIDTH+1)'(BYTES))
                     - (ADDR_WIDTH+1)'(1);
    assign reject    = (last_byte[ADDR_WIDTH:10] != {1'b0, cmd_addr[ADDR_WIDTH-1:10]});
`else
    assign reject    = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision: acceptance, beat progression, BUSY insertion, errors
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept && !reject) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (err_first) begin
                    state_nxt = S_ERR;
                end else if (HREADY) begin
                    if (beats_rem == '0) begin
                        state_nxt = S_LAST;
                    end else if (HTRANS == T_NONSEQ && busy_n != '0) begin
                        state_nxt = S_BUSYW;
                    end
                end
            end
            S_BUSYW: begin
                if (err_first) begin
                    state_nxt = S_ERR;
                end else if (HREADY && busy_cnt == BUSY_W'(1)) begin
                    state_nxt = S_ADDR;
                end
            end
            S_LAST: begin
                if (err_first) begin
                    state_nxt = S_ERR;
                end else if (HREADY) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (HREADY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered bus outputs, read stream and completion flags
    always_comb begin
        haddr_nxt     = HADDR;
        htrans_nxt    = HTRANS;
        hwrite_nxt    = HWRITE;
        hburst_nxt    = HBURST;
        hwdata_nxt    = HWDATA;
        rdata_nxt     = rdata;
        rvalid_nxt    = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        beats_rem_nxt = beats_rem;
        busy_n_nxt    = busy_n;
        busy_cnt_nxt  = busy_cnt;
        dphase_nxt    = dphase;

        if (dphase && HREADY) begin
            dphase_nxt = 1'b0;
            if (!HWRITE && state != S_ERR) begin
                rdata_nxt  = HRDATA;
                rvalid_nxt = 1'b1;
            end
        end
        if (addr_acc) begin
            dphase_nxt = 1'b1;
        end
        if (wdata_pop) begin
            hwdata_nxt = wdata;
        end

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        done_nxt  = 1'b1;
                        error_nxt = 1'b1;
                    end else begin
                        haddr_nxt     = cmd_addr;
                        htrans_nxt    = T_NONSEQ;
                        hwrite_nxt    = cmd_write;
                        hburst_nxt    = burst_code(eff_beats);
                        beats_rem_nxt = eff_beats - BEAT_W'(1);
                        busy_n_nxt    = cmd_busy;
                    end
                end
            end
            S_ADDR: begin
                if (err_first) begin
                    htrans_nxt = T_IDLE;
                end else if (HREADY) begin
                    if (beats_rem == '0) begin
                        htrans_nxt = T_IDLE;
                    end else begin
                        haddr_nxt     = HADDR + ADDR_STEP;
                        beats_rem_nxt = beats_rem - BEAT_W'(1);
                        if (HTRANS == T_NONSEQ && busy_n != '0) begin
                            htrans_nxt   = T_BUSY;
                            busy_cnt_nxt = busy_n;
                        end else begin
                            htrans_nxt = T_SEQ;
                        end
                    end
                end
            end
            S_BUSYW: begin
                if (err_first) begin
                    htrans_nxt = T_IDLE;
                end else if (HREADY) begin
                    busy_cnt_nxt = busy_cnt - BUSY_W'(1);
                    if (busy_cnt == BUSY_W'(1)) htrans_nxt = T_SEQ;
                end
            end
            S_LAST: begin
                if (err_first) begin
                    htrans_nxt = T_IDLE;
                end else if (HREADY) begin
                    done_nxt = 1'b1;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                end
            end
            default: htrans_nxt = T_IDLE;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR       <= '0;
            HTRANS      <= T_IDLE;
            HWRITE      <= 1'b0;
            HBURST      <= 3'b000;
            HWDATA      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            beats_rem   <= '0;
            busy_n      <= '0;
            busy_cnt    <= '0;
            dphase      <= 1'b0;
        end else begin
            HADDR       <= haddr_nxt;
            HTRANS      <= htrans_nxt;
            HWRITE      <= hwrite_nxt;
            HBURST      <= hburst_nxt;
            HWDATA      <= hwdata_nxt;
            rdata       <= rdata_nxt;
            rdata_valid <= rvalid_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            beats_rem   <= beats_rem_nxt;
            busy_n      <= busy_n_nxt;
            busy_cnt    <= busy_cnt_nxt;
            dphase      <= dphase_nxt;
        end
    end

endmodule
